// File: rtl/tt_um_aditya_patra_pkg.sv
// Shared types, channel count and parameter defaults for the eight-channel sensor buzzer.
// Build option: BUZZER_TONE_EN selects a toggling tone instead of a steady buzzer level.
package tt_um_aditya_patra_pkg;

    localparam int NUM_CH              = 8;
    localparam int TONE_DIV_DEFAULT    = 2;
    localparam int HOLD_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_ALARM = 2'd1,
        CH_HOLD  = 2'd2
    } ch_state_e;

    function automatic logic [3:0] popcount8(input logic [7:0] vec);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/buzzer_channel.sv
// One sensor channel: IDLE/ALARM/HOLD state machine, hold timer and buzzer drive.
// Build option: BUZZER_TONE_EN adds the tone divider and phase toggling.
module buzzer_channel
    import tt_um_aditya_patra_pkg::*;
#(
    parameter int TONE_DIV    = TONE_DIV_DEFAULT,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sense,
    output logic active,
    output logic buzz
);

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    ch_state_e  state_r;
    ch_state_e  state_nxt_s;
    logic [3:0] hold_cnt_r;
    logic [3:0] hold_nxt_s;
    logic       tone_start_s;
    logic       active_s;

    assign active_s = (state_r == CH_ALARM) || (state_r == CH_HOLD);

    // Next-state and hold-timer decode from the registered sensor bit.
    always_comb begin
        state_nxt_s  = state_r;
        hold_nxt_s   = hold_cnt_r;
        tone_start_s = 1'b0;
        case (state_r)
            CH_IDLE: begin
                if (sense) begin
                    state_nxt_s  = CH_ALARM;
                    tone_start_s = 1'b1;
                end else begin
                    state_nxt_s  = CH_IDLE;
                end
            end
            CH_ALARM: begin
                if (sense) begin
                    state_nxt_s = CH_ALARM;
                end else begin
                    state_nxt_s = CH_HOLD;
                    hold_nxt_s  = HOLD_LOAD;
                end
            end
            CH_HOLD: begin
                // Re-trigger goes straight back to ALARM; the tone keeps running.
                if (sense) begin
                    state_nxt_s = CH_ALARM;
                end else if (hold_cnt_r != 4'd0) begin
                    hold_nxt_s  = hold_cnt_r - 4'd1;
                end else begin
                    state_nxt_s = CH_IDLE;
                end
            end
            default: begin
                state_nxt_s = CH_IDLE;
                hold_nxt_s  = 4'd0;
            end
        endcase
    end

    // State and hold-timer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= CH_IDLE;
            hold_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_nxt_s;
        end
    end

`ifdef BUZZER_TONE_EN
    localparam logic [3:0] TONE_LAST = 4'(TONE_DIV - 1);

    logic [3:0] tone_cnt_r;
    logic       phase_r;

    // Tone divider: restarts high on entry to ALARM, free-runs while active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tone_cnt_r <= 4'd0;
            phase_r    <= 1'b0;
        end else if (tone_start_s) begin
            tone_cnt_r <= 4'd0;
            phase_r    <= 1'b1;
        end else if (active_s) begin
            if (tone_cnt_r == TONE_LAST) begin
                tone_cnt_r <= 4'd0;
                phase_r    <= ~phase_r;
            end else begin
                tone_cnt_r <= tone_cnt_r + 4'd1;
            end
        end else begin
            tone_cnt_r <= 4'd0;
            phase_r    <= 1'b0;
        end
    end

    assign buzz = active_s & phase_r;
`else
    logic [3:0] unused_tone_div_s;
    logic       unused_tone_start_s;

    assign unused_tone_div_s   = 4'(TONE_DIV);
    assign unused_tone_start_s = tone_start_s;
    assign buzz                = active_s;
`endif

    assign active = active_s;

endmodule

// File: rtl/tt_um_aditya_patra.sv
// Eight independent sensor-to-buzzer alarm channels with a registered sensor stage and status popcount.
// Build option: BUZZER_TONE_EN makes each buzzer a square-wave tone rather than a steady level.
module tt_um_aditya_patra
    import tt_um_aditya_patra_pkg::*;
#(
    parameter int TONE_DIV    = TONE_DIV_DEFAULT,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [NUM_CH-1:0] sensor_r;
    logic [NUM_CH-1:0] active_s;
    logic [NUM_CH-1:0] buzz_s;
    logic [3:0]        active_cnt_s;
    logic              any_active_s;
    logic              unused_s;

    // Sensor sampling stage; channels only ever see this registered copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sensor_r <= 8'h00;
        end else begin
            sensor_r <= ui_in;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        buzzer_channel #(
            .TONE_DIV    (TONE_DIV),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_channel (
            .clk    (clk),
            .rst_n  (rst_n),
            .sense  (sensor_r[g]),
            .active (active_s[g]),
            .buzz   (buzz_s[g])
        );
    end

    assign active_cnt_s = popcount8(active_s);
    assign any_active_s = |active_s;

    assign uo_out   = buzz_s;
    assign uio_out  = {3'b000, any_active_s, active_cnt_s};
    assign uio_oe   = 8'hFF;
    assign unused_s = ^{ena, uio_in};

endmodule

// File: tb/tb_tt_um_aditya_patra.sv
// Scoreboard bench for tt_um_aditya_patra: a cycle model pushes expected outputs, sampled results pop and compare.
module tb_tt_um_aditya_patra;

    localparam int TD = 2;
    localparam int HC = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks;
    int n_fail;

    // model state per channel: 0 idle, 1 alarm, 2 hold
    int         m_state [8];
    int         m_tone  [8];
    int         m_hold  [8];
    logic       m_phase [8];
    logic [7:0] m_s;

    logic [15:0] exp_q[$];
    logic [7:0]  last_uo;

    tt_um_aditya_patra dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic [7:0] v, input logic rst);
        for (int i = 0; i < 8; i++) begin
            if (rst) begin
                m_state[i] = 0; m_tone[i] = 0; m_hold[i] = 0; m_phase[i] = 1'b0;
            end else begin
                if (m_state[i] != 0) begin
                    if (m_tone[i] == TD - 1) begin
                        m_tone[i]  = 0;
                        m_phase[i] = ~m_phase[i];
                    end else begin
                        m_tone[i] = m_tone[i] + 1;
                    end
                end else begin
                    m_tone[i] = 0; m_phase[i] = 1'b0;
                end
                case (m_state[i])
                    0: if (m_s[i]) begin m_state[i] = 1; m_phase[i] = 1'b1; m_tone[i] = 0; end
                    1: if (!m_s[i]) begin m_state[i] = 2; m_hold[i] = HC - 1; end
                    2: begin
                        if (m_s[i]) m_state[i] = 1;
                        else if (m_hold[i] != 0) m_hold[i] = m_hold[i] - 1;
                        else m_state[i] = 0;
                    end
                    default: m_state[i] = 0;
                endcase
            end
        end
        m_s = rst ? 8'h00 : v;
    endtask

    function automatic logic [15:0] model_out();
        logic [7:0] uo;
        logic [3:0] cnt;
        uo  = 8'h00;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (m_state[i] != 0) begin
                cnt = cnt + 4'd1;
`ifdef BUZZER_TONE_EN
                uo[i] = m_phase[i];
`else
                uo[i] = 1'b1;
`endif
            end
        end
        return {uo, 3'b000, (cnt != 4'd0), cnt};
    endfunction

    task automatic run_cycle(input logic [7:0] v, input logic rst);
        logic [15:0] exp;
        @(negedge clk);
        ui_in  = v;
        rst_n  = ~rst;
        uio_in = 8'($urandom);
        ena    = 1'($urandom);
        model_step(v, rst);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check_eq("uo_out", uo_out, exp[15:8]);
        check_eq("uio_out", uio_out, exp[7:0]);
        last_uo = uo_out;
    endtask

    task automatic run_n(input logic [7:0] v, input int n);
        for (int k = 0; k < n; k++) run_cycle(v, 1'b0);
    endtask

    logic [9:0] pat;
    logic [9:0] exp_pat;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ena      = 1'b1;
        ui_in    = 8'h00;
        uio_in   = 8'h00;
        m_s      = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_state[i] = 0; m_tone[i] = 0; m_hold[i] = 0; m_phase[i] = 1'b0;
        end

        // reset
        run_cycle(8'h00, 1'b1);
        check_eq("rst_uo", uo_out, 8'h00);
        check_eq("rst_uio", uio_out, 8'h00);
        check_eq("uio_oe", uio_oe, 8'hFF);

        // single sensor, tone pattern on channel 0
        for (int k = 0; k < 10; k++) begin
            run_cycle(8'h01, 1'b0);
            pat[k] = last_uo[0];
        end
`ifdef BUZZER_TONE_EN
        exp_pat = 10'b1001100110;
`else
        exp_pat = 10'b1111111110;
`endif
        check_eq("pat_lo", pat[7:0], exp_pat[7:0]);
        check_eq("pat_hi", {6'd0, pat[9:8]}, {6'd0, exp_pat[9:8]});
        check_eq("single_uio", uio_out, 8'h11);

        // hold tail: one pipeline cycle plus HC hold cycles stay active
        for (int k = 0; k < 1 + HC; k++) begin
            run_cycle(8'h00, 1'b0);
            check_eq("hold_uio", uio_out, 8'h11);
        end
        run_cycle(8'h00, 1'b0);
        check_eq("hold_end_uo", uo_out, 8'h00);
        check_eq("hold_end_uio", uio_out, 8'h00);

        // re-trigger during hold: never reaches idle
        run_n(8'h01, 6);
        for (int k = 0; k < 3; k++) run_cycle(8'h00, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_cycle(8'h01, 1'b0);
            check_eq("retrig_uio", uio_out, 8'h11);
        end
        run_n(8'h00, 8);

        // two sensors in lockstep
        for (int k = 0; k < 40; k++) begin
            run_cycle(8'h06, 1'b0);
            check_eq("lockstep", {7'd0, uo_out[2]}, {7'd0, uo_out[1]});
        end
        check_eq("two_uio", uio_out, 8'h12);
        run_n(8'h00, 8);

        // all sensors
        run_n(8'hFF, 20);
        check_eq("all_uio", uio_out, 8'h18);
        run_n(8'h00, 1 + HC + 1);
        check_eq("all_idle_uo", uo_out, 8'h00);
        check_eq("all_idle_uio", uio_out, 8'h00);

        // reset mid-alarm and mid-hold: no hold tail
        run_n(8'hFF, 5);
        run_cycle(8'hFF, 1'b1);
        check_eq("rst_alarm_uio", uio_out, 8'h00);
        run_n(8'h00, 2);
        run_n(8'h01, 5);
        run_n(8'h00, 2);
        run_cycle(8'h00, 1'b1);
        check_eq("rst_hold_uio", uio_out, 8'h00);
        run_n(8'h00, 2);

        // random sensor traffic
        for (int k = 0; k < 300; k++) begin
            run_cycle(8'($urandom) & 8'($urandom), 1'b0);
        end
        run_n(8'h00, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
